// File: rtl/fifo_sync_param_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
package fifo_sync_param_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 16;

  localparam int unsigned RD_REG  = 0;
  localparam int unsigned RD_FWFT = 1;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Producer/consumer bus of the synchronous FIFO; slave is the FIFO side.
interface fifo_sync_param_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned AW     = 4
);
  logic              wr;
  logic              rd;
  logic [DATA_W-1:0] data_in;
  logic              clr_flags;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic [AW:0]       count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_almost_full;
  logic              fifo_almost_empty;
  logic              fifo_overflow;
  logic              fifo_underflow;

  modport master (
    output wr, rd, data_in, clr_flags,
    input  data_out, data_valid, count, fifo_full, fifo_empty,
           fifo_almost_full, fifo_almost_empty, fifo_overflow, fifo_underflow
  );

  modport slave (
    input  wr, rd, data_in, clr_flags,
    output data_out, data_valid, count, fifo_full, fifo_empty,
           fifo_almost_full, fifo_almost_empty, fifo_overflow, fifo_underflow
  );
endinterface

// File: rtl/fifo_sync_param_ram.sv
// Simple dual-port storage: synchronous write, registered or combinational read.
module fifo_ram
  import fifo_sync_param_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned FWFT   = RD_REG,
  parameter int unsigned AW     = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  if (FWFT == RD_FWFT) begin : g_comb_rd
    logic unused_c;
    assign unused_c = ^{re, rst};
    assign rdata    = mem_q[raddr];
  end else begin : g_reg_rd
    // Read register doubles as the FIFO output word, hence the reset.
    logic [DATA_W-1:0] rdata_q;
    always_ff @(posedge clk) begin
      if (rst)     rdata_q <= '0;
      else if (re) rdata_q <= mem_q[raddr];
    end
    assign rdata = rdata_q;
  end

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO with occupancy count, threshold flags and
// sticky overflow/underflow; read mode is registered or first-word-fall-through.
module fifo_sync_param
  import fifo_sync_param_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned AFULL_TH  = 12,
  parameter int unsigned AEMPTY_TH = 2,
  parameter int unsigned FWFT      = RD_REG
) (
  input logic              clk,
  input logic              rst,
  fifo_sync_param_if.slave bus
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if (DATA_W < 1) begin : g_bad_data_w
    $error("fifo_sync_param: DATA_W must be >= 1");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_sync_param: DEPTH must be a power of two >= 4");
  end
  if (AFULL_TH < 1 || AFULL_TH > DEPTH - 1) begin : g_bad_afull
    $error("fifo_sync_param: AFULL_TH must be in 1..DEPTH-1");
  end
  if (AEMPTY_TH > DEPTH - 2) begin : g_bad_aempty
    $error("fifo_sync_param: AEMPTY_TH must be in 0..DEPTH-2");
  end
  if (FWFT > RD_FWFT) begin : g_bad_fwft
    $error("fifo_sync_param: FWFT must be 0 or 1");
  end
  if ($bits(bus.data_in) != DATA_W || $bits(bus.count) != CW) begin : g_bad_bus
    $error("fifo_sync_param: interface widths do not match DATA_W/DEPTH");
  end

  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q, afull_q, aempty_q;
  logic          ovf_q, ovf_d, udf_q, udf_d;
  logic          valid_q, valid_d;
  logic          wr_ok_c, rd_ok_c;

  logic              ram_re;
  logic [AW-1:0]     ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

  // Accept decisions, next pointers/count and sticky flags.
  always_comb begin
    rd_ok_c = bus.rd & ~empty_q;
    wr_ok_c = bus.wr & (~full_q | rd_ok_c);
    wptr_d  = wr_ok_c ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = rd_ok_c ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q;
    case ({wr_ok_c, rd_ok_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ovf_d   = (bus.wr & full_q & ~bus.rd) | (ovf_q & ~bus.clr_flags);
    udf_d   = (bus.rd & empty_q) | (udf_q & ~bus.clr_flags);
    valid_d = (FWFT == RD_FWFT) ? (count_d != '0) : rd_ok_c;
  end

  // Status flags are registered from the next count so they track count_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CW'(DEPTH));
      empty_q  <= (count_d == '0);
      afull_q  <= (count_d >= CW'(AFULL_TH));
      aempty_q <= (count_d <= CW'(AEMPTY_TH));
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      valid_q  <= valid_d;
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .FWFT   (FWFT),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok_c),
    .waddr (wptr_q),
    .wdata (bus.data_in),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  if (FWFT == RD_FWFT) begin : g_fwft
    logic [DATA_W-1:0] data_out_q;
    logic              bypass_c;

    // The next head is the word being written only when it lands on the new read slot.
    assign bypass_c  = wr_ok_c & (wptr_q == rptr_d);
    assign ram_re    = 1'b0;
    assign ram_raddr = rptr_d;

    always_ff @(posedge clk) begin
      if (rst)                  data_out_q <= '0;
      else if (count_d != '0)   data_out_q <= bypass_c ? bus.data_in : ram_rdata;
    end
    assign bus.data_out = data_out_q;
  end else begin : g_reg
    assign ram_re       = rd_ok_c;
    assign ram_raddr    = rptr_q;
    assign bus.data_out = ram_rdata;
  end

  assign bus.data_valid        = valid_q;
  assign bus.count             = count_q;
  assign bus.fifo_full         = full_q;
  assign bus.fifo_empty        = empty_q;
  assign bus.fifo_almost_full  = afull_q;
  assign bus.fifo_almost_empty = aempty_q;
  assign bus.fifo_overflow     = ovf_q;
  assign bus.fifo_underflow    = udf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench: a registered-read FIFO and an FWFT FIFO driven by directed vectors.
module tb_fifo_sync_param;

  logic clk;
  logic rst;

  int checks;
  int failures;

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  fifo_sync_param_if #(.DATA_W(8), .AW(4)) b0 ();
  fifo_sync_param_if #(.DATA_W(8), .AW(4)) b1 ();

  fifo_sync_param #(
    .DATA_W(8), .DEPTH(16), .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(0)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  fifo_sync_param #(
    .DATA_W(8), .DEPTH(16), .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(1)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic wr, input logic rd, input logic [7:0] d, input logic clr);
    b0.wr = wr; b0.rd = rd; b0.data_in = d; b0.clr_flags = clr;
  endtask

  task automatic drive1(input logic wr, input logic rd, input logic [7:0] d, input logic clr);
    b1.wr = wr; b1.rd = rd; b1.data_in = d; b1.clr_flags = clr;
  endtask

  // Registered-read monitor: every data_valid pulse consumes one expected word.
  always @(negedge clk) begin
    if (!rst && b0.data_valid === 1'b1) begin
      if (q0.size() == 0) begin
        chk("dut0_unexpected_output", 32'(b0.data_out), 32'hFFFF_FFFF);
      end else begin
        chk("dut0_data_out", 32'(b0.data_out), 32'(q0.pop_front()));
      end
    end
  end

  // FWFT monitor: a read against a non-empty FIFO consumes the presented head word.
  always @(negedge clk) begin
    if (!rst && b1.rd === 1'b1 && b1.fifo_empty === 1'b0) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected_output", 32'(b1.data_out), 32'hFFFF_FFFF);
      end else begin
        chk("dut1_head", 32'(b1.data_out), 32'(q1.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    drive0(1'b0, 1'b0, 8'h00, 1'b0);
    drive1(1'b0, 1'b0, 8'h00, 1'b0);

    // Reset state
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_count", 32'(b0.count), 32'd0);
    chk("rst_empty", 32'(b0.fifo_empty), 32'd1);
    chk("rst_aempty", 32'(b0.fifo_almost_empty), 32'd1);
    chk("rst_full", 32'(b0.fifo_full), 32'd0);
    chk("rst_afull", 32'(b0.fifo_almost_full), 32'd0);
    chk("rst_ovf", 32'(b0.fifo_overflow), 32'd0);
    chk("rst_udf", 32'(b0.fifo_underflow), 32'd0);
    chk("rst_data_out", 32'(b0.data_out), 32'd0);
    chk("rst_valid", 32'(b0.data_valid), 32'd0);
    chk("rst_valid_fwft", 32'(b1.data_valid), 32'd0);

    // 1: fill with 1..16, then drain in order
    for (int i = 1; i <= 16; i++) begin
      drive0(1'b1, 1'b0, 8'(i), 1'b0);
      q0.push_back(8'(i));
      step();
      chk("fill_count", 32'(b0.count), 32'(i));
      chk("fill_afull", 32'(b0.fifo_almost_full), (i >= 12) ? 32'd1 : 32'd0);
      chk("fill_full", 32'(b0.fifo_full), (i == 16) ? 32'd1 : 32'd0);
      chk("fill_aempty", 32'(b0.fifo_almost_empty), (i <= 2) ? 32'd1 : 32'd0);
    end
    for (int i = 1; i <= 16; i++) begin
      drive0(1'b0, 1'b1, 8'h00, 1'b0);
      step();
      chk("drain_count", 32'(b0.count), 32'(16 - i));
      chk("drain_valid", 32'(b0.data_valid), 32'd1);
    end
    drive0(1'b0, 1'b0, 8'h00, 1'b0);
    step();
    chk("drain_valid_single", 32'(b0.data_valid), 32'd0);
    chk("drain_empty", 32'(b0.fifo_empty), 32'd1);
    chk("drain_sb_empty", 32'(q0.size()), 32'd0);

    // 2: overflow on a full FIFO drops 0xAA; clear removes the flag
    for (int i = 1; i <= 16; i++) begin
      drive0(1'b1, 1'b0, 8'(100 + i), 1'b0);
      q0.push_back(8'(100 + i));
      step();
    end
    drive0(1'b1, 1'b0, 8'hAA, 1'b0);
    step();
    chk("ovf_set", 32'(b0.fifo_overflow), 32'd1);
    chk("ovf_count", 32'(b0.count), 32'd16);
    drive0(1'b0, 1'b0, 8'h00, 1'b1);
    step();
    chk("ovf_clr", 32'(b0.fifo_overflow), 32'd0);

    // 3: simultaneous write/read when full keeps count at DEPTH
    drive0(1'b1, 1'b1, 8'h55, 1'b0);
    q0.push_back(8'h55);
    step();
    chk("full_wr_rd_count", 32'(b0.count), 32'd16);
    chk("full_wr_rd_ovf", 32'(b0.fifo_overflow), 32'd0);
    chk("full_wr_rd_valid", 32'(b0.data_valid), 32'd1);
    for (int i = 0; i < 16; i++) begin
      drive0(1'b0, 1'b1, 8'h00, 1'b0);
      step();
    end
    drive0(1'b0, 1'b0, 8'h00, 1'b0);
    step();
    chk("t3_empty", 32'(b0.fifo_empty), 32'd1);
    chk("t3_sb_empty", 32'(q0.size()), 32'd0);

    // 4: underflow holds data_out; write+read on empty accepts only the write
    drive0(1'b0, 1'b1, 8'h00, 1'b0);
    step();
    chk("udf_set", 32'(b0.fifo_underflow), 32'd1);
    chk("udf_count", 32'(b0.count), 32'd0);
    chk("udf_data_hold", 32'(b0.data_out), 32'h55);
    drive0(1'b1, 1'b1, 8'h33, 1'b0);
    q0.push_back(8'h33);
    step();
    chk("empty_wr_rd_count", 32'(b0.count), 32'd1);
    chk("empty_wr_rd_udf", 32'(b0.fifo_underflow), 32'd1);
    chk("empty_wr_rd_data", 32'(b0.data_out), 32'h55);
    chk("empty_wr_rd_valid", 32'(b0.data_valid), 32'd0);
    drive0(1'b0, 1'b1, 8'h00, 1'b0);
    step();
    chk("read_33_empty", 32'(b0.fifo_empty), 32'd1);
    drive0(1'b0, 1'b1, 8'h00, 1'b1);
    step();
    chk("udf_set_beats_clr", 32'(b0.fifo_underflow), 32'd1);
    drive0(1'b0, 1'b0, 8'h00, 1'b1);
    step();
    chk("udf_clr", 32'(b0.fifo_underflow), 32'd0);
    drive0(1'b0, 1'b0, 8'h00, 1'b0);

    // 6: reset mid-stream discards stored words
    for (int i = 0; i < 10; i++) begin
      drive0(1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
      step();
    end
    chk("pre_rst_count", 32'(b0.count), 32'd10);
    drive0(1'b1, 1'b0, 8'h6A, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive0(1'b0, 1'b0, 8'h00, 1'b0);
    chk("mid_rst_count", 32'(b0.count), 32'd0);
    chk("mid_rst_empty", 32'(b0.fifo_empty), 32'd1);
    chk("mid_rst_flags", 32'({b0.fifo_full, b0.fifo_almost_full, b0.fifo_overflow, b0.fifo_underflow}), 32'd0);
    chk("mid_rst_data", 32'(b0.data_out), 32'd0);
    drive0(1'b1, 1'b0, 8'h7E, 1'b0);
    q0.push_back(8'h7E);
    step();
    drive0(1'b0, 1'b1, 8'h00, 1'b0);
    step();
    drive0(1'b0, 1'b0, 8'h00, 1'b0);
    step();
    chk("t6_sb_empty", 32'(q0.size()), 32'd0);

    // 5: FWFT head presentation, advance, hold while empty, bypass on write+read
    drive1(1'b1, 1'b0, 8'h10, 1'b0);
    q1.push_back(8'h10);
    step();
    chk("fwft_first_data", 32'(b1.data_out), 32'h10);
    chk("fwft_first_valid", 32'(b1.data_valid), 32'd1);
    drive1(1'b1, 1'b0, 8'h20, 1'b0);
    q1.push_back(8'h20);
    step();
    chk("fwft_head_stable", 32'(b1.data_out), 32'h10);
    chk("fwft_count2", 32'(b1.count), 32'd2);
    drive1(1'b0, 1'b1, 8'h00, 1'b0);
    step();
    chk("fwft_advance", 32'(b1.data_out), 32'h20);
    chk("fwft_valid_after_rd", 32'(b1.data_valid), 32'd1);
    step();
    chk("fwft_empty", 32'(b1.fifo_empty), 32'd1);
    chk("fwft_valid_empty", 32'(b1.data_valid), 32'd0);
    chk("fwft_hold", 32'(b1.data_out), 32'h20);
    drive1(1'b1, 1'b0, 8'h40, 1'b0);
    q1.push_back(8'h40);
    step();
    chk("fwft_40", 32'(b1.data_out), 32'h40);
    drive1(1'b1, 1'b1, 8'h41, 1'b0);
    q1.push_back(8'h41);
    step();
    chk("fwft_bypass_data", 32'(b1.data_out), 32'h41);
    chk("fwft_bypass_count", 32'(b1.count), 32'd1);
    drive1(1'b0, 1'b1, 8'h00, 1'b0);
    step();
    chk("fwft_drained", 32'(b1.fifo_empty), 32'd1);
    step();
    chk("fwft_udf", 32'(b1.fifo_underflow), 32'd1);
    chk("fwft_udf_hold", 32'(b1.data_out), 32'h41);
    drive1(1'b0, 1'b0, 8'h00, 1'b0);
    step();
    chk("fwft_sb_empty", 32'(q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
